rv_mc_datapath_hs: RTL and testbench
====================================

Name: rv_mc_datapath_hs

Overview:
Parametrised next-generation multicycle RISC-V datapath. The microcode/FSM controller stays external and drives the same style of per-cycle control strobes. Adds a variable-latency req/ack memory port with an internal wait-state FSM, byte-enable stores, sub-word load extension, configurable width, register count and reset vector. Sits between the team's multicycle controller and the system memory/bus fabric.

Parameters:
XLEN, 32, datapath width; 32 only for RV32, other values reserved for future RV64 work
NREG, 32, architectural registers; 32 (RV32I) or 16 (RV32E)
RESET_PC, 32'h0000_0000, PC value on reset
AW, 32, memory address width; mem_addr = low AW bits of the selected address

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
PCWrite, AdrSrc, IRWrite, RegWrite  in  1 each  controller strobes; AdrSrc=0 selects PC, 1 selects ALUOut
MemStart  in  1  begin a memory transaction using the current Adr
MemWE  in  1  transaction is a store
ResultSrc, ALUSrcA, ALUSrcB  in  2 each  mux selects: Result 0=ALUOut, 1=load data, 2=ALUResult; SrcA 0=PC, 1=OldPC, 2=A; SrcB 0=B, 1=ImmExt, 2=4
ALUControl  in  4  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra; others yield 0
ImmSrc  in  3  0 I, 1 S, 2 B, 3 U, 4 J
op  out  7  IR[6:0]
funct3  out  3  IR[14:12]
funct7_5  out  1  IR[30]
zero  out  1  ALUResult == 0
mem_busy  out  1  transaction in flight; controller must hold
mem_done  out  1  one-cycle pulse when a transaction completes
mem_req  out  1  bus request
mem_we  out  1  bus write
mem_be  out  4  byte enables
mem_addr  out  AW  byte address, word-aligned (bits [1:0] = 0)
mem_wdata  out  XLEN  store data
mem_rdata  in  XLEN  read data, valid with mem_ack
mem_ack  in  1  transaction accept/complete

Behaviour:
- Async reset (reset_n=0): PC=RESET_PC; OldPC, IR, MDR, A, B, ALUOut = 0; FSM=IDLE; mem_req, mem_we, mem_be, mem_done, mem_busy = 0. Register file contents are not reset.
- Every edge: A, B <= rf[rs1], rf[rs2]; ALUOut <= ALUResult. PC <= Result when PCWrite. rf[rd] <= Result when RegWrite and rd != 0.
- Register file with NREG=16: only index bits [3:0] are used; writes to rd >= 16 are ignored; reads of index >= 16 return 0. x0 always reads 0.
- Memory FSM has states IDLE, REQ and DONE.
  - IDLE: on MemStart, latch addr = Adr, byte offset = Adr[1:0], MemWE, funct3 and the write data, then go to REQ.
  - REQ: mem_req=1 and bus outputs are held stable. On mem_ack, capture mem_rdata (reads only) and go to DONE.
  - DONE: mem_done=1 for one cycle, then back to IDLE. The controller may assert MemStart in DONE; the FSM goes straight to REQ and the new request is accepted.
- mem_busy is 1 in REQ and also in the MemStart cycle (combinational).
- MemStart while in REQ is ignored.
- Zero-wait memory (mem_ack in the first REQ cycle): minimum latency is MemStart edge to mem_done = 2 cycles.
- A read with IRWrite=1 held during the transaction writes IR <= mem_rdata and OldPC <= PC on the ack edge. Every read writes MDR.
- Stores, byte-enables by funct3:
  - sb: be = 0001 << off, wdata = B[7:0] replicated 4x
  - sh: be = 0011 << (off & 2), wdata = B[15:0] replicated 2x
  - sw: be = 1111
  - reads drive be = 1111
- Load data (ResultSrc=1) comes from MDR shifted right by 8 x latched offset, then extended by latched funct3: lb/lh sign-extend, lbu/lhu zero-extend, lw unchanged.
- Shifts use SrcB[4:0]. slt is signed, sltu is unsigned.
- ImmExt uses the standard RV32I encodings; U-type is imm[31:12] with 12 zero bits below.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: adds output misalign (1 bit). Checks at MemStart: halfword with off=3, or word with off!=0. On a fault, no mem_req is issued; FSM goes IDLE->DONE with misalign=1 and mem_done=1 for that cycle, and MDR is unchanged. misalign clears on the next MemStart or on reset.
- Undefined: no check. Misaligned halfwords use be=1100 with the upper-half alignment; misaligned words use be=1111 at the aligned address.

Test Plan:
- Reset: reset_n low mid-REQ -> mem_req=0 immediately; after release PC=RESET_PC (32'h0), mem_busy=0.
- Fetch with 3 wait states: MemStart+IRWrite at PC=0, mem_ack on the 4th REQ cycle with rdata=32'h00500093 -> op=7'h13, mem_done pulses exactly 1 cycle, OldPC=0.
- Store: sb, B=32'h1234_56AB, Adr=0x103 -> mem_be=1000, mem_wdata=32'hABAB_ABAB, mem_addr=0x100.
- Load: lh, Adr=0x102, rdata=32'h8001_7FFF -> load result 32'hFFFF_8001; lhu -> 32'h0000_8001.
- ALU: SrcA=32'h8000_0000, SrcB=1, sra -> 32'hC000_0000; sub with equal operands -> zero=1; NREG=16 write to x20 -> read x20=0.
- Back-to-back: MemStart in DONE with zero-wait ack -> second mem_done exactly 2 cycles after the first; with MISALIGN_TRAP_EN, lw at 0x102 -> misalign=1, no mem_req.

Source files
------------

// File: rtl/rv_mc_datapath_hs.sv
// rv_mc_datapath_hs: multicycle RV32 datapath driven by an external controller.
// The memory port uses req/ack handshaking with a wait-state FSM (IDLE/REQ/DONE).
// It supports byte-enable stores and sign/zero-extended sub-word loads.
// Optional build macro MISALIGN_TRAP_EN adds the misalign output. A misaligned
// halfword or word access then completes without a bus request.
module rv_mc_datapath_hs #(
    parameter int               XLEN     = 32,
    parameter int               NREG     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000,
    parameter int               AW       = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            PCWrite,
    input  logic            AdrSrc,
    input  logic            IRWrite,
    input  logic            RegWrite,
    input  logic            MemStart,
    input  logic            MemWE,
    input  logic [1:0]      ResultSrc,
    input  logic [1:0]      ALUSrcA,
    input  logic [1:0]      ALUSrcB,
    input  logic [3:0]      ALUControl,
    input  logic [2:0]      ImmSrc,
    output logic [6:0]      op,
    output logic [2:0]      funct3,
    output logic            funct7_5,
    output logic            zero,
    output logic            mem_busy,
    output logic            mem_done,
    output logic            mem_req,
    output logic            mem_we,
    output logic [3:0]      mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack
`ifdef MISALIGN_TRAP_EN
    ,
    output logic            misalign
`endif
);

    localparam int         RIDX   = $clog2(NREG);
    localparam logic [5:0] NREG_L = 6'(NREG);

    typedef enum logic [1:0] {IDLE, REQ, DONE} mem_state_t;

    mem_state_t state, next_state;

    logic [XLEN-1:0] pc, old_pc, ir, mdr, a_r, b_r, alu_out;
    logic [XLEN-1:0] rf [NREG];
    logic [XLEN-1:0] rd_a, rd_b, imm_ext, src_a, src_b, alu_res, result, adr, load_data;
    logic signed [XLEN-1:0] src_a_s, src_b_s;
    logic [4:0]      rs1, rs2, rd;
    logic            accept, fault, ack_read;

    // latched transaction context
    logic [AW-1:2]   addr_l;
    logic [1:0]      off_l;
    logic            we_l;
    logic [2:0]      f3_l;
    logic [3:0]      be_l;
    logic [XLEN-1:0] wdata_l;

    // load lane select and extension
    function automatic logic [31:0] load_ext(input logic [31:0] raw, input logic [1:0] off,
                                             input logic [2:0] f3);
        logic [31:0] sh;
        sh = raw >> {off, 3'b000};
        case (f3)
            3'b000:  load_ext = {{24{sh[7]}}, sh[7:0]};
            3'b001:  load_ext = {{16{sh[15]}}, sh[15:0]};
            3'b100:  load_ext = {24'b0, sh[7:0]};
            3'b101:  load_ext = {16'b0, sh[15:0]};
            default: load_ext = sh;
        endcase
    endfunction

    // byte enables for a transaction; reads always take the full word
    function automatic logic [3:0] store_be(input logic we, input logic [2:0] f3,
                                            input logic [1:0] off);
        if (!we)
            store_be = 4'b1111;
        else begin
            case (f3[1:0])
                2'b00:   store_be = 4'b0001 << off;
                2'b01:   store_be = 4'b0011 << {off[1], 1'b0};
                default: store_be = 4'b1111;
            endcase
        end
    endfunction

    // store data replicated across all lanes the enables may select
    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] b);
        case (f3[1:0])
            2'b00:   store_data = {4{b[7:0]}};
            2'b01:   store_data = {2{b[15:0]}};
            default: store_data = b;
        endcase
    endfunction

    assign op       = ir[6:0];
    assign funct3   = ir[14:12];
    assign funct7_5 = ir[30];
    assign rs1      = ir[19:15];
    assign rs2      = ir[24:20];
    assign rd       = ir[11:7];

    // x0 and indices beyond the implemented file read as zero
    assign rd_a = (rs1 == 5'd0 || {1'b0, rs1} >= NREG_L) ? '0 : rf[rs1[RIDX-1:0]];
    assign rd_b = (rs2 == 5'd0 || {1'b0, rs2} >= NREG_L) ? '0 : rf[rs2[RIDX-1:0]];

    // immediate decode
    always_comb begin
        imm_ext = '0;
        case (ImmSrc)
            3'd0: imm_ext = {{20{ir[31]}}, ir[31:20]};
            3'd1: imm_ext = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            3'd2: imm_ext = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            3'd3: imm_ext = {ir[31:12], 12'b0};
            3'd4: imm_ext = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: imm_ext = '0;
        endcase
    end

    // ALU operand selection
    always_comb begin
        src_a = '0;
        src_b = '0;
        case (ALUSrcA)
            2'd0: src_a = pc;
            2'd1: src_a = old_pc;
            2'd2: src_a = a_r;
            default: src_a = '0;
        endcase
        case (ALUSrcB)
            2'd0: src_b = b_r;
            2'd1: src_b = imm_ext;
            2'd2: src_b = 32'd4;
            default: src_b = '0;
        endcase
    end

    assign src_a_s = src_a;
    assign src_b_s = src_b;

    // ALU
    always_comb begin
        alu_res = '0;
        case (ALUControl)
            4'd0: alu_res = src_a + src_b;
            4'd1: alu_res = src_a - src_b;
            4'd2: alu_res = src_a & src_b;
            4'd3: alu_res = src_a | src_b;
            4'd4: alu_res = src_a ^ src_b;
            4'd5: alu_res = {{(XLEN-1){1'b0}}, (src_a_s < src_b_s)};
            4'd6: alu_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            4'd7: alu_res = src_a << src_b[4:0];
            4'd8: alu_res = src_a >> src_b[4:0];
            4'd9: alu_res = XLEN'(src_a_s >>> src_b[4:0]);
            default: alu_res = '0;
        endcase
    end

    assign zero      = (alu_res == '0);
    assign adr       = AdrSrc ? alu_out : pc;
    assign load_data = load_ext(mdr, off_l, f3_l);

    // result bus back to PC and register file
    always_comb begin
        result = '0;
        case (ResultSrc)
            2'd0: result = alu_out;
            2'd1: result = load_data;
            2'd2: result = alu_res;
            default: result = '0;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    assign fault = ((funct3[1:0] == 2'b01) && (adr[1:0] == 2'b11)) ||
                   ((funct3[1:0] == 2'b10) && (adr[1:0] != 2'b00));
`else
    assign fault = 1'b0;
`endif

    // memory FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    // memory FSM next state; a new request is accepted from IDLE or DONE only
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (MemStart) begin
                    accept     = 1'b1;
                    next_state = fault ? DONE : REQ;
                end
            end
            REQ: begin
                if (mem_ack)
                    next_state = DONE;
            end
            DONE: begin
                next_state = IDLE;
                if (MemStart) begin
                    accept     = 1'b1;
                    next_state = fault ? DONE : REQ;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign ack_read  = (state == REQ) && mem_ack && !we_l;
    assign mem_req   = (state == REQ);
    assign mem_we    = (state == REQ) && we_l;
    assign mem_be    = (state == REQ) ? be_l : 4'b0000;
    assign mem_addr  = {addr_l, 2'b00};
    assign mem_wdata = wdata_l;
    assign mem_done  = (state == DONE);
    assign mem_busy  = (state == REQ) || MemStart;

    // transaction context captured when a request is accepted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_l  <= '0;
            off_l   <= 2'b00;
            we_l    <= 1'b0;
            f3_l    <= 3'b000;
            be_l    <= 4'b0000;
            wdata_l <= '0;
        end else if (accept) begin
            addr_l  <= adr[AW-1:2];
            off_l   <= adr[1:0];
            we_l    <= MemWE;
            f3_l    <= funct3;
            be_l    <= store_be(MemWE, funct3, adr[1:0]);
            wdata_l <= store_data(funct3, b_r);
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic misalign_r;

    // fault flag holds until the next accepted request
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            misalign_r <= 1'b0;
        else if (accept)
            misalign_r <= fault;
    end

    assign misalign = misalign_r;
`endif

    // architectural and inter-cycle datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc      <= RESET_PC;
            old_pc  <= '0;
            ir      <= '0;
            mdr     <= '0;
            a_r     <= '0;
            b_r     <= '0;
            alu_out <= '0;
        end else begin
            a_r     <= rd_a;
            b_r     <= rd_b;
            alu_out <= alu_res;
            if (PCWrite)
                pc <= result;
            if (ack_read) begin
                mdr <= mem_rdata;
                if (IRWrite) begin
                    ir     <= mem_rdata;
                    old_pc <= pc;
                end
            end
        end
    end

    // register file write port; x0 and unimplemented registers are never written
    always_ff @(posedge clk) begin
        if (RegWrite && rd != 5'd0 && {1'b0, rd} < NREG_L)
            rf[rd[RIDX-1:0]] <= result;
    end

endmodule

// File: tb/tb_rv_mc_datapath_hs.sv
// Directed testbench for rv_mc_datapath_hs (built with NREG=16).
// Values are observed through decode outputs, zero and the memory port.
// Register contents are read back by fetching a store that drives them onto mem_wdata.
module tb_rv_mc_datapath_hs;

    logic        clk, reset_n;
    logic        PCWrite, AdrSrc, IRWrite, RegWrite, MemStart, MemWE;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
    logic [3:0]  ALUControl;
    logic [2:0]  ImmSrc;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7_5, zero, mem_busy, mem_done, mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
`ifdef MISALIGN_TRAP_EN
    logic        misalign;
`endif

    int checks = 0;
    int errors = 0;

    rv_mc_datapath_hs #(.NREG(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .MemStart(MemStart), .MemWE(MemWE),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .ImmSrc(ImmSrc),
        .op(op), .funct3(funct3), .funct7_5(funct7_5), .zero(zero),
        .mem_busy(mem_busy), .mem_done(mem_done), .mem_req(mem_req), .mem_we(mem_we),
        .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef MISALIGN_TRAP_EN
        , .misalign(misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // store that reads register r onto the bus: sw xr, r(xr)
    function automatic logic [31:0] probe_instr(input logic [4:0] r);
        return {7'b0, r, r, 3'b010, r, 7'h23};
    endfunction

    task automatic set_alu(input logic [1:0] sa, input logic [1:0] sb,
                           input logic [3:0] alu, input logic [2:0] imm);
        ALUSrcA = sa; ALUSrcB = sb; ALUControl = alu; ImmSrc = imm;
    endtask

    // one execute cycle that writes Result to rd
    task automatic exec(input logic [1:0] sa, input logic [1:0] sb, input logic [3:0] alu,
                        input logic [2:0] imm, input logic [1:0] res);
        set_alu(sa, sb, alu, imm);
        ResultSrc = res;
        RegWrite  = 1'b1;
        tick();
        RegWrite  = 1'b0;
    endtask

    // full memory transaction with a given number of wait states
    task automatic txn(input logic we, input int waits, input logic [31:0] rdata,
                       input logic [31:0] exp_addr);
        MemStart = 1'b1;
        MemWE    = we;
        tick();
        MemStart = 1'b0;
        chk("req_first", mem_req, 1);
        chk("req_addr", mem_addr, exp_addr);
        for (int i = 0; i < waits; i++) begin
            tick();
            chk("req_wait", mem_req, 1);
            chk("done_wait", mem_done, 0);
        end
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        tick();
        mem_ack   = 1'b0;
        chk("done_hi", mem_done, 1);
        chk("req_after_ack", mem_req, 0);
        tick();
        chk("done_lo", mem_done, 0);
        MemWE = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] instr, input int waits);
        AdrSrc  = 1'b0;
        IRWrite = 1'b1;
        txn(1'b0, waits, instr, 32'h0);
        IRWrite = 1'b0;
    endtask

    // read register r back via a store at PC
    task automatic probe(input string tag, input logic [4:0] r, input logic [31:0] exp);
        fetch(probe_instr(r), 0);
        AdrSrc   = 1'b0;
        MemStart = 1'b1;
        MemWE    = 1'b1;
        tick();
        MemStart = 1'b0;
        chk(tag, mem_wdata, exp);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        MemWE = 1'b0;
    endtask

    // ALUOut <= x0 + immediate of the current instruction
    task automatic addr_from_imm(input logic [2:0] imm);
        set_alu(2'd2, 2'd1, 4'd0, imm);
        tick();
        AdrSrc = 1'b1;
    endtask

    task automatic store_chk(input string tag, input logic [3:0] be, input logic [31:0] wd,
                             input logic [31:0] addr);
        MemStart = 1'b1;
        MemWE    = 1'b1;
        tick();
        MemStart = 1'b0;
        chk({tag, "_we"}, mem_we, 1);
        chk({tag, "_be"}, mem_be, be);
        chk({tag, "_wdata"}, mem_wdata, wd);
        chk({tag, "_addr"}, mem_addr, addr);
        tick();
        chk({tag, "_be_held"}, mem_be, be);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk({tag, "_done"}, mem_done, 1);
        tick();
        MemWE  = 1'b0;
        AdrSrc = 1'b0;
    endtask

    task automatic load_chk(input string tag, input logic [31:0] instr, input logic [31:0] rdata,
                            input logic [31:0] exp);
        fetch(instr, 0);
        addr_from_imm(3'd0);
        txn(1'b0, 1, rdata, 32'h100);
        AdrSrc = 1'b0;
        exec(2'd0, 2'd0, 4'd0, 3'd0, 2'd1);
        probe(tag, 5'd5, exp);
    endtask

    initial begin
        reset_n = 1'b0;
        PCWrite = 0; AdrSrc = 0; IRWrite = 0; RegWrite = 0; MemStart = 0; MemWE = 0;
        ResultSrc = 0; ALUSrcA = 0; ALUSrcB = 0; ALUControl = 0; ImmSrc = 0;
        mem_rdata = '0; mem_ack = 0;
        tick(); tick();

        // reset state
        chk("rst_req", mem_req, 0);
        chk("rst_be", mem_be, 0);
        chk("rst_done", mem_done, 0);
        chk("rst_busy", mem_busy, 0);
        chk("rst_op", op, 0);
        chk("rst_zero", zero, 1);
        reset_n = 1'b1;
        tick();

        // move PC to 4, start a fetch and reset in the middle of REQ
        set_alu(2'd0, 2'd2, 4'd0, 3'd0);
        ResultSrc = 2'd2;
        PCWrite   = 1'b1;
        tick();
        PCWrite  = 1'b0;
        MemStart = 1'b1;
        #1 chk("busy_start", mem_busy, 1);
        tick();
        MemStart = 1'b0;
        chk("pc4_addr", mem_addr, 32'h4);
        tick();
        #2 reset_n = 1'b0;
        #1 chk("rst_async_req", mem_req, 0);
        #2 reset_n = 1'b1;
        tick();
        chk("rst_rel_busy", mem_busy, 0);

        // fetch with three wait states at the reset vector
        fetch(32'h0050_0093, 3);
        chk("fetch_op", op, 7'h13);
        chk("fetch_f3", funct3, 0);
        exec(2'd1, 2'd1, 4'd0, 3'd0, 2'd2);
        probe("oldpc_plus5", 5'd1, 32'd5);

        // build x6 = 0x123456AB, then sb and misaligned sh
        fetch(32'h1234_5337, 0);
        exec(2'd1, 2'd1, 4'd0, 3'd3, 2'd2);
        fetch(32'h6AB3_0313, 0);
        exec(2'd2, 2'd1, 4'd0, 3'd0, 2'd2);
        fetch(32'h1060_01A3, 0);
        addr_from_imm(3'd1);
        store_chk("sb", 4'b1000, 32'hABAB_ABAB, 32'h100);
`ifndef MISALIGN_TRAP_EN
        fetch(32'h1060_11A3, 0);
        addr_from_imm(3'd1);
        store_chk("sh_off3", 4'b1100, 32'h56AB_56AB, 32'h100);
`endif

        // sub-word loads at 0x102
        load_chk("lh", 32'h1020_1283, 32'h8001_7FFF, 32'hFFFF_8001);
        load_chk("lhu", 32'h1020_5283, 32'h8001_7FFF, 32'h0000_8001);

        // arithmetic shift right of 0x80000000 by 1
        fetch(32'h8000_02B7, 0);
        exec(2'd1, 2'd1, 4'd0, 3'd3, 2'd2);
        fetch(32'h4012_D293, 0);
        chk("srai_op", op, 7'h13);
        chk("srai_f3", funct3, 3'd5);
        chk("srai_f7", funct7_5, 1);
        exec(2'd2, 2'd1, 4'd9, 3'd0, 2'd2);
        probe("sra", 5'd5, 32'hC000_0000);

        // A = B = x5 after the probe fetch
        set_alu(2'd2, 2'd0, 4'd1, 3'd0);
        #1 chk("sub_eq_zero", zero, 1);
        set_alu(2'd2, 2'd0, 4'd0, 3'd0);
        #1 chk("add_nz_zero", zero, 0);
        set_alu(2'd2, 2'd0, 4'd15, 3'd0);
        #1 chk("undef_op_zero", zero, 1);

        // a write to x20 is dropped and x4 keeps its own value
        fetch(32'h1234_5237, 0);
        exec(2'd1, 2'd1, 4'd0, 3'd3, 2'd2);
        fetch(32'h8000_0A37, 0);
        exec(2'd1, 2'd1, 4'd0, 3'd3, 2'd2);
        probe("x20_reads0", 5'd20, 32'h0);
        probe("x4_kept", 5'd4, 32'h1234_5000);

        // back-to-back zero-wait reads: second request issued in DONE
        AdrSrc   = 1'b0;
        MemStart = 1'b1;
        tick();
        MemStart = 1'b0;
        mem_ack  = 1'b1;
        tick();
        mem_ack  = 1'b0;
        chk("b2b_done1", mem_done, 1);
        MemStart = 1'b1;
        #1 chk("b2b_busy_done", mem_busy, 1);
        tick();
        MemStart = 1'b0;
        chk("b2b_req2", mem_req, 1);
        chk("b2b_gap", mem_done, 0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("b2b_done2", mem_done, 1);
        tick();
        chk("b2b_idle", mem_done, 0);

`ifdef MISALIGN_TRAP_EN
        // lw at 0x102 traps without a bus request
        fetch(32'h1020_2283, 0);
        addr_from_imm(3'd0);
        MemStart = 1'b1;
        tick();
        MemStart = 1'b0;
        chk("mis_flag", misalign, 1);
        chk("mis_done", mem_done, 1);
        chk("mis_noreq", mem_req, 0);
        tick();
        chk("mis_done_lo", mem_done, 0);
        chk("mis_hold", misalign, 1);
        AdrSrc = 1'b0;
        txn(1'b0, 0, 32'h0, 32'h0);
        chk("mis_clear", misalign, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
